// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types for the byte-addressed data memory.
//   size_e  - access size encoding carried on req_size (log2 of bytes)
//   state_e - controller state: CLEAR (post-reset zero fill) or RUN
//   size_bytes() - number of bytes touched by a given size encoding
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the MEM stage and data_mem.
//   master: drives req_valid/req_we/req_addr/req_size/req_signed/req_wdata,
//           observes req_ready, rsp_valid/rsp_rdata/rsp_err and init_done.
//   slave : the memory side, directions reversed.
interface data_mem_if #(
  parameter int ADDR_W = 16,
  parameter int NBYTES = 2
);

  localparam int DW = 8 * NBYTES;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DW-1:0]     req_wdata;
  logic              rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
  );

endinterface

// File: rtl/data_mem_lane.sv
// data_mem_lane: one byte lane of the data memory.
//   clk   - clock
//   we    - write enable for this lane
//   addr  - word index (shared by read and write)
//   wdata - byte to store
//   rdata - registered read of mem[addr] from the previous edge
// The array has no reset; the top level zero-fills it after reset.
module data_mem_lane #(
  parameter int IDX_W = 15
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] addr,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [0:(1<<IDX_W)-1];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem.sv
// data_mem: byte-addressed little-endian data memory for the MEM stage.
//   clk   - clock, all state on the rising edge
//   rst_n - synchronous active-low reset; restarts the zero-fill sequence
//   bus   - data_mem_if.slave: valid/ready request, 1-cycle registered response
// After reset the memory is zero-filled one word per cycle (CLEAR), then
// requests are accepted every cycle (RUN). Misaligned or oversized accesses
// leave memory untouched and answer with rsp_err = 1 and zero data.
module data_mem
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int NBYTES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  localparam int DW     = 8 * NBYTES;
  localparam int LOG2NB = $clog2(NBYTES);
  localparam int OFF_W  = (LOG2NB > 0) ? LOG2NB : 1;
  localparam int IDX_W  = ADDR_W - LOG2NB;
  // Only the low three address bits can matter for alignment (max 8 bytes).
  localparam int CHK_W  = (ADDR_W < 3) ? ADDR_W : 3;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_load_q, rsp_load_d;
  logic              rsp_signed_q, rsp_signed_d;
  logic [1:0]        rsp_size_q, rsp_size_d;
  logic [OFF_W-1:0]  rsp_off_q, rsp_off_d;

  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              misalign, oversize, req_err;
  logic              accept, store_ok, clearing;

  logic [NBYTES-1:0] lane_we;
  logic [IDX_W-1:0]  lane_addr;
  logic [DW-1:0]     rd_word;

  // Address split: word index selects the row, offset selects the first lane.
  assign req_idx = bus.req_addr[ADDR_W-1:LOG2NB];

  generate
    if (LOG2NB > 0) begin : g_off
      assign req_off = bus.req_addr[OFF_W-1:0];
    end else begin : g_no_off
      assign req_off = '0;
    end
  endgenerate

  always_comb begin
    misalign = 1'b0;
    for (int i = 0; i < CHK_W; i++) begin
      if (i < int'(bus.req_size)) begin
        misalign = misalign | bus.req_addr[i];
      end
    end
  end

  assign oversize = int'(bus.req_size) > LOG2NB;
  assign req_err  = misalign | oversize;
  assign accept   = bus.req_valid & ready_q;
  assign store_ok = accept & bus.req_we & ~req_err;
  assign clearing = (state_q == ST_CLEAR);

  assign lane_addr = clearing ? cnt_q : req_idx;

  // Lane gi receives store byte (gi - offset); aligned accesses never wrap,
  // so the modular subtraction only ever lands on bytes that are in range.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [OFF_W-1:0] src;
      logic             in_range;
      logic [7:0]       wbyte;

      assign src      = OFF_W'(gi) - req_off;
      assign in_range = (gi >= int'(req_off)) &&
                        ((gi - int'(req_off)) < size_bytes(bus.req_size));
      // Reset low suppresses every write, including a store accepted that edge.
      assign lane_we[gi] = rst_n & (clearing | (store_ok & in_range));
      assign wbyte       = clearing ? 8'h00 : bus.req_wdata[8*src +: 8];

      data_mem_lane #(
        .IDX_W (IDX_W)
      ) u_lane (
        .clk   (clk),
        .we    (lane_we[gi]),
        .addr  (lane_addr),
        .wdata (wbyte),
        .rdata (rd_word[8*gi +: 8])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_d = ST_RUN;
      end
    end
    ready_d      = (state_d == ST_RUN);
    done_d       = (state_d == ST_RUN);
    rsp_valid_d  = accept;
    rsp_err_d    = accept & req_err;
    rsp_load_d   = accept & ~bus.req_we & ~req_err;
    rsp_size_d   = bus.req_size;
    rsp_signed_d = bus.req_signed;
    rsp_off_d    = req_off;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_load_q   <= 1'b0;
      rsp_size_q   <= 2'd0;
      rsp_signed_q <= 1'b0;
      rsp_off_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_load_q   <= rsp_load_d;
      rsp_size_q   <= rsp_size_d;
      rsp_signed_q <= rsp_signed_d;
      rsp_off_q    <= rsp_off_d;
    end
  end

  // Response cycle: rotate the registered row down to the access offset,
  // then zero- or sign-extend above the accessed width.
  logic [DW-1:0] shifted;
  logic [DW-1:0] rdata_ext;
  logic          sign_bit;
  int            nbits;

  always_comb begin
    shifted  = rd_word >> {rsp_off_q, 3'b000};
    nbits    = 8 * size_bytes(rsp_size_q);
    sign_bit = 1'b0;
    for (int i = 0; i < DW; i++) begin
      if (i == nbits - 1) begin
        sign_bit = shifted[i];
      end
    end
    for (int i = 0; i < DW; i++) begin
      rdata_ext[i] = (i < nbits) ? shifted[i] : (rsp_signed_q & sign_bit);
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.init_done = done_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_load_q ? rdata_ext : '0;

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised, byte-addressed, little-endian data memory that replaces the fixed 16-bit memory. It has a valid/ready request port, byte, halfword and word accesses, and a registered 1-cycle read. It detects misaligned accesses and clears its contents after reset with a counter-driven sequence instead of a single-cycle clear. It sits on the CPU's MEM stage and serves both loads and stores.

## Interface
- `ADDR_W`, default 16: byte-address width; capacity is 2**ADDR_W bytes.
- `NBYTES`, default 2: bytes per data word; power of two, 1 to 8, and less than 2**ADDR_W.
- `clk` in, 1: single clock; all state updates on its rising edge.
- `rst_n` in, 1: reset, synchronous and active-low.
- `req_valid` in, 1: request present.
- `req_ready` out, 1: block can accept a request this cycle.
- `req_we` in, 1: 1 = store, 0 = load.
- `req_addr` in, ADDR_W: byte address.
- `req_size` in, 2: log2 of access bytes (0 = byte, 1 = half, 2 = word, 3 = dword).
- `req_signed` in, 1: sign-extend narrow loads.
- `req_wdata` in, 8*NBYTES: store data; only the low (1<<req_size) bytes are used.
- `rsp_valid` out, 1: one-cycle pulse per accepted request.
- `rsp_rdata` out, 8*NBYTES: load data, zero- or sign-extended; 0 for stores and errors.
- `rsp_err` out, 1: accepted request was misaligned or oversized.
- `init_done` out, 1: clear sequence complete.

## Operation
- States: CLEAR and RUN. Reset forces CLEAR with the clear counter at 0.
- CLEAR behaviour:
  - Writes zero to all NBYTES lanes at word index `cnt` each cycle.
  - `cnt` runs from 0 to 2**ADDR_W/NBYTES-1.
  - After the last index, the block moves to RUN.
  - `req_ready` = 0 throughout.
- RUN behaviour: `req_ready` = 1 and `init_done` = 1, held until reset.
- A request is accepted when `req_valid` and `req_ready` are both high at a clock edge.
- Error condition: `req_size` > log2(NBYTES), or `req_addr` mod (1<<req_size) != 0.
  - On error, memory is unchanged.
  - Response has `rsp_err` = 1 and `rsp_rdata` = 0.
- Store: byte at `req_addr`+k takes `req_wdata`[8k+7:8k], for k < (1<<req_size). Other bytes are untouched.
- Load: byte k of the result comes from `req_addr`+k. The upper bits are filled with zero, or with bit 8*(1<<req_size)-1 when `req_signed` is set.
- Lane mapping:
  - Lane = `req_addr`[log2(NBYTES)-1:0] + k.
  - Word index = `req_addr`[ADDR_W-1:log2(NBYTES)].
  - Alignment guarantees an access never straddles words and never wraps.
- Only one request per cycle. A load accepted in the cycle after a store to the same byte returns the stored value.

## Timing
- Reset values: `req_ready` = 0, `init_done` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Clear duration: 2**ADDR_W/NBYTES cycles after `rst_n` rises. `req_ready` rises the cycle after the last clear write.
- Store commits at the accepting edge.
- Load data is registered: `rsp_valid`, `rsp_rdata` and `rsp_err` appear exactly 1 cycle after acceptance.
- Back-to-back accepted requests give back-to-back responses.
- No response backpressure: a consumer must take `rsp_*` in the cycle `rsp_valid` = 1.
- `rsp_valid` is 0 in any cycle not following an acceptance.
- Reset asserted mid-operation or mid-clear:
  - The pending response is dropped (`rsp_valid` = 0 next cycle).
  - No store commits in that cycle.
  - The clear sequence restarts from index 0.
- `req_*` inputs are ignored while `req_ready` = 0.

## Structure
- Package `data_mem_pkg`:
  - Size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`/`SZ_DWORD`.
  - State enum {`ST_CLEAR`, `ST_RUN`}.
- Sub-module `data_mem_lane`, instantiated NBYTES times:
  - One byte-wide array of 2**ADDR_W/NBYTES entries.
  - Write-enable input and synchronous registered read.
- Top level holds:
  - the FSM and clear counter;
  - alignment/error check;
  - lane rotation for store data;
  - registered size, signed and lane offset, used for load data realignment and extension on the response cycle.

## Test plan
- Reset clear (ADDR_W = 8, NBYTES = 2): write nonzero data, pulse `rst_n` low 1 cycle → `req_ready` = 0 for 128 cycles, then 1; a load of any address returns 0.
- Halfword store then byte loads: store half 0xBEEF @0x10, then load byte @0x10 → 0x00EF; load byte @0x11 with `req_signed` = 1 → 0xFFBE.
- Byte store preserves the neighbour: store half 0x1234 @0x20, store byte 0xAB @0x21, then load half @0x20 → 0xAB34 on the cycle after acceptance.
- Misaligned access: store half 0x5555 @0x31 → `rsp_err` = 1, `rsp_rdata` = 0; load half @0x30 → prior value unchanged; `req_size` = 2 with NBYTES = 2 → `rsp_err` = 1.
- Back-to-back: store @0x40 followed by an immediate load @0x40 on consecutive cycles → two consecutive `rsp_valid` pulses; the load returns the stored data.
- Reset mid-operation: accept a load, assert `rst_n` on the next edge → `rsp_valid` = 0, `init_done` = 0, and the clear restarts (128 cycles).
